// File: rtl/scs8hd_ano_pipe.sv
// Parametrised, pipelined AND-OR(-INVERT) cell array: X = OR(AND groups, direct OR terms) ^ INV
// per lane, with a 2-stage valid/ready pipeline and a saturating output-toggle counter.
module scs8hd_ano_pipe #(
    parameter int LANES = 2,
    parameter int N_AND = 2,
    parameter int K     = 2,
    parameter int N_OR  = 1,
    parameter int CNT_W = 8
) (
    input  logic                                         CLK,
    input  logic                                         RESET,
    input  logic [LANES*N_AND*K-1:0]                     A,
    input  logic [((LANES*N_OR > 0) ? LANES*N_OR : 1)-1:0] C,
    input  logic                                         INV,
    input  logic                                         IN_VALID,
    output logic                                         IN_READY,
    output logic [LANES-1:0]                             X,
    output logic                                         OUT_VALID,
    input  logic                                         OUT_READY,
    output logic [CNT_W-1:0]                             TOG_CNT,
    input  logic                                         CNT_CLR
);

    localparam int C_W = (LANES*N_OR > 0) ? LANES*N_OR : 1;
    localparam int G_W = LANES*N_AND;

    generate
        if (K < 1 || N_AND < 1 || LANES < 1) begin : g_param_check
            $fatal(1, "scs8hd_ano_pipe: K, N_AND and LANES must all be at least 1");
        end
    endgenerate

    logic             s1_valid;
    logic             s2_valid;
    logic [G_W-1:0]   p_s1;
    logic [C_W-1:0]   c_s1;
    logic             inv_s1;
    logic [LANES-1:0] prev_x;

    logic             adv1;
    logic             adv2;
    logic             out_acc;
    logic [G_W-1:0]   p_comb;
    logic [LANES-1:0] y_comb;

    assign adv2      = s1_valid & (~s2_valid | OUT_READY);
    assign IN_READY  = ~RESET & (~s1_valid | adv2);
    assign adv1      = IN_VALID & IN_READY;
    assign OUT_VALID = s2_valid;
    assign out_acc   = s2_valid & OUT_READY;

    // NOTE: every always_comb output gets a default before any conditional logic, so no latch can form.
    always_comb begin
        p_comb = '0;
        for (int i = 0; i < G_W; i++) begin
            p_comb[i] = &A[i*K +: K];
        end
    end

    always_comb begin
        y_comb = '0;
        for (int l = 0; l < LANES; l++) begin
            for (int g = 0; g < N_AND; g++) begin
                y_comb[l] = y_comb[l] | p_s1[l*N_AND + g];
            end
            for (int j = 0; j < N_OR; j++) begin
                y_comb[l] = y_comb[l] | c_s1[l*N_OR + j];
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_valid <= 1'b0;
        end else if (adv1) begin
            s1_valid <= 1'b1;
        end else if (adv2) begin
            s1_valid <= 1'b0;
        end
    end

    // NOTE: stage-1 payload has no reset; it is only observed behind s1_valid, which is reset.
    always_ff @(posedge CLK) begin
        if (adv1) begin
            p_s1   <= p_comb;
            c_s1   <= C;
            inv_s1 <= INV;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s2_valid <= 1'b0;
            X        <= '0;
        end else if (adv2) begin
            s2_valid <= 1'b1;
            X        <= y_comb ^ {LANES{inv_s1}};
        end else if (OUT_READY) begin
            s2_valid <= 1'b0;
        end
    end

    // Clear beats a coincident increment; prev_x tracks every accepted beat regardless of clear.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            TOG_CNT <= '0;
            prev_x  <= '0;
        end else begin
            if (out_acc) begin
                prev_x <= X;
            end
            if (CNT_CLR) begin
                TOG_CNT <= '0;
            end else if (out_acc && (X != prev_x) && (TOG_CNT != {CNT_W{1'b1}})) begin
                TOG_CNT <= TOG_CNT + 1'b1;
            end
        end
    end

endmodule
